// File: rtl/issue_window_if.sv
// Issue broadcast / positioner / MAC-consumer signal bundle for one allocator receiver.
// Latency: none, pure wiring.
// Backpressure: issue_block back to the broadcaster; out_valid/out_ready toward the MAC datapath.
interface issue_window_if #(
  parameter int DATA_W = 18
);
  logic [7:0]        positioner_x;
  logic [7:0]        positioner_y;
  logic              positioner_sel;
  logic [1:0]        filter_halfsize;
  logic [8:0]        image_depth;
  logic [7:0]        issue_x;
  logic [7:0]        issue_y;
  logic [DATA_W-1:0] issue_data;
  logic              issue_en;
  logic              issue_block;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_dx;
  logic [2:0]        out_dy;
  logic              out_valid;
  logic              out_ready;
  logic              window_done;
  logic              overflow;
  logic              busy;

  // Positioner, broadcaster and MAC consumer side
  modport master (
    output positioner_x, positioner_y, positioner_sel, filter_halfsize, image_depth,
    output issue_x, issue_y, issue_data, issue_en, out_ready,
    input  issue_block, out_data, out_dx, out_dy, out_valid, window_done, overflow, busy
  );

  // Receiver side
  modport slave (
    input  positioner_x, positioner_y, positioner_sel, filter_halfsize, image_depth,
    input  issue_x, issue_y, issue_data, issue_en, out_ready,
    output issue_block, out_data, out_dx, out_dy, out_valid, window_done, overflow, busy
  );
endinterface

// File: rtl/issue_window_receiver.sv
// Captures in-window beats of the issue broadcast into a FWFT FIFO tagged with tap (dx,dy).
// Latency: beat accepted at edge N is visible at the FIFO head in cycle N+1 when empty.
// Backpressure: registered issue_block once occupancy >= depth-2; beats on a full FIFO are dropped (sticky overflow).
module issue_window_receiver #(
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = 18
) (
  input  logic          clk,
  input  logic          rst,
  issue_window_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DATA_W + 6;
  localparam logic [CW-1:0] FULL_LVL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BLOCK_LVL = CW'(FIFO_DEPTH - 2);

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Window configuration latched at select
  logic [7:0]  cx_q, cy_q;
  logic [1:0]  hs_q;
  logic [14:0] total_q;
  logic [14:0] beat_cnt_q;

  // Expected beat count: (2hs+1)^2 taps times channel depth
  logic [2:0]  side;
  logic [5:0]  side_sq;
  logic [14:0] total_calc;
  assign side       = {bus.filter_halfsize, 1'b1};
  assign side_sq    = {3'b000, side} * {3'b000, side};
  assign total_calc = {9'd0, side_sq} * {6'd0, bus.image_depth};

  // Window test done in 9 bits so a centre near 255 never wraps onto x=0/1
  logic [8:0] hs9, x9, y9, cx9, cy9;
  logic       in_x, in_y, in_win;
  logic [2:0] dx, dy;
  assign hs9    = {7'd0, hs_q};
  assign x9     = {1'b0, bus.issue_x};
  assign y9     = {1'b0, bus.issue_y};
  assign cx9    = {1'b0, cx_q};
  assign cy9    = {1'b0, cy_q};
  assign in_x   = (x9 + hs9 >= cx9) && (x9 <= cx9 + hs9);
  assign in_y   = (y9 + hs9 >= cy9) && (y9 <= cy9 + hs9);
  assign in_win = in_x && in_y;
  // Tap offsets only need the low 3 bits; modular arithmetic keeps them exact
  assign dx = bus.issue_x[2:0] - cx_q[2:0] + {1'b0, hs_q};
  assign dy = bus.issue_y[2:0] - cy_q[2:0] + {1'b0, hs_q};

  // Capture FIFO storage and bookkeeping
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          fifo_vld, fifo_full;
  logic [EW-1:0] head;
  assign fifo_vld  = (count_q != '0);
  assign fifo_full = (count_q == FULL_LVL);
  assign head      = mem[rd_ptr_q];

  // Select wins over everything in its cycle: same-cycle beat ignored, pop suppressed by flush
  logic beat, do_push, do_pop, drop, last_beat;
  assign beat      = (state_q == CAPTURE) && bus.issue_en && in_win && !bus.positioner_sel;
  assign do_pop    = fifo_vld && bus.out_ready && !bus.positioner_sel;
  assign do_push   = beat && (!fifo_full || do_pop);
  assign drop      = beat && fifo_full && !do_pop;
  assign last_beat = beat && ((beat_cnt_q + 15'd1) == total_q);

  // Next-state logic for the capture FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.positioner_sel) state_d = CAPTURE;
      CAPTURE: begin
        if (bus.positioner_sel) state_d = CAPTURE;
        else if (last_beat)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latch window centre, halfsize and expected total on select
  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q    <= '0;
      cy_q    <= '0;
      hs_q    <= '0;
      total_q <= '0;
    end else if (bus.positioner_sel) begin
      cx_q    <= bus.positioner_x;
      cy_q    <= bus.positioner_y;
      hs_q    <= bus.filter_halfsize;
      total_q <= total_calc;
    end
  end

  // Beat counter counts every in-window beat, including ones dropped on overflow
  always_ff @(posedge clk) begin
    if (rst)                     beat_cnt_q <= '0;
    else if (bus.positioner_sel) beat_cnt_q <= '0;
    else if (beat)               beat_cnt_q <= beat_cnt_q + 15'd1;
  end

  // Post-update FIFO occupancy
  always_comb begin
    count_d = count_q;
    if (bus.positioner_sel)     count_d = '0;
    else if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  // FIFO pointers and occupancy; select flushes the FIFO
  always_ff @(posedge clk) begin
    if (rst || bus.positioner_sel) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // FIFO storage write; contents are qualified by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= {dx, dy, bus.issue_data};
  end

  // Registered status: early block with a 2-entry margin, done pulse, sticky overflow
  logic issue_block_q, window_done_q, overflow_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_block_q <= 1'b0;
      window_done_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      issue_block_q <= (count_d >= BLOCK_LVL);
      window_done_q <= last_beat;
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign bus.issue_block = issue_block_q;
  assign bus.window_done = window_done_q;
  assign bus.overflow    = overflow_q;
  assign bus.busy        = (state_q == CAPTURE);
  assign bus.out_valid   = fifo_vld;
  assign {bus.out_dx, bus.out_dy, bus.out_data} = fifo_vld ? head : '0;
endmodule

// File: tb/tb_issue_window_receiver.sv
// Directed bench for issue_window_receiver with an 8-entry FIFO.
// Inputs change on the falling edge; outputs are sampled 1ns after the falling edge.
// Popped entries and done pulses are recorded by a monitor and checked by the test tasks.
module tb_issue_window_receiver;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  issue_window_if #(.DATA_W(18)) bus ();

  issue_window_receiver #(.FIFO_DEPTH(8), .DATA_W(18)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] popq[$];
  int done_cnt = 0;

  // Monitor: record every pop (dx,dy,data) and every window_done pulse
  always begin
    @(negedge clk);
    #1;
    if (rst !== 1'b1) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && bus.positioner_sel !== 1'b1)
        popq.push_back({bus.out_dx, bus.out_dy, bus.out_data});
      if (bus.window_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  task automatic settle(input logic rdy);
    @(negedge clk);
    bus.issue_en = 1'b0;
    bus.positioner_sel = 1'b0;
    bus.out_ready = rdy;
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [17:0] d, input logic rdy);
    @(negedge clk);
    bus.positioner_sel = 1'b0;
    bus.issue_en = 1'b1;
    bus.issue_x = x;
    bus.issue_y = y;
    bus.issue_data = d;
    bus.out_ready = rdy;
  endtask

  task automatic select(input logic [7:0] cx, input logic [7:0] cy, input logic [1:0] hs,
                        input logic [8:0] dep, input logic rdy, input logic en);
    @(negedge clk);
    bus.positioner_sel = 1'b1;
    bus.positioner_x = cx;
    bus.positioner_y = cy;
    bus.filter_halfsize = hs;
    bus.image_depth = dep;
    bus.issue_en = en;
    bus.issue_x = cx - 8'd1;
    bus.issue_y = cy - 8'd1;
    bus.issue_data = 18'h3FFFF;
    bus.out_ready = rdy;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b1) break;
      settle(1'b1);
    end
    settle(1'b0);
    settle(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.positioner_sel = 1'b0; bus.positioner_x = '0; bus.positioner_y = '0;
    bus.filter_halfsize = '0; bus.image_depth = '0;
    bus.issue_en = 1'b1; bus.issue_x = 8'd3; bus.issue_y = 8'd3; bus.issue_data = 18'h1;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.issue_block !== 1'b0) begin n_fail++; $display("FAIL reset_issue_block: got %b want 0", bus.issue_block); end
    n_checks++; if (bus.window_done !== 1'b0) begin n_fail++; $display("FAIL reset_window_done: got %b want 0", bus.window_done); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    n_checks++; if (bus.out_data !== 18'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'(i), 8'(i), 18'(i + 1), 1'b0);
      settle(1'b0);
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_beat_ignored: got out_valid %b want 0", bus.out_valid); end
    end
  endtask

  task automatic test_raster();
    int pbase, dbase, idx;
    logic [23:0] got, exp;
    pbase = popq.size(); dbase = done_cnt;
    select(8'd5, 8'd5, 2'd1, 9'd1, 1'b1, 1'b0);
    settle(1'b1);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL raster_busy_start: got %b want 1", bus.busy); end
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++)
        send(8'(x), 8'(y), 18'(y * 10 + x), 1'b1);
    repeat (3) settle(1'b1);
    n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL raster_done_pulses: got %0d want 1", done_cnt - dbase); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL raster_busy_end: got %b want 0", bus.busy); end
    n_checks++; if (popq.size() - pbase !== 9) begin n_fail++; $display("FAIL raster_count: got %0d want 9", popq.size() - pbase); end
    for (int dy = 0; dy < 3; dy++)
      for (int dx = 0; dx < 3; dx++) begin
        idx = pbase + dy * 3 + dx;
        exp = {3'(dx), 3'(dy), 18'((4 + dy) * 10 + 4 + dx)};
        got = (idx < popq.size()) ? popq[idx] : 24'hxxxxxx;
        n_checks++; if (got !== exp) begin n_fail++; $display("FAIL raster_entry%0d: got %h want %h", dy * 3 + dx, got, exp); end
      end
  endtask

  task automatic test_edge();
    int coords[6] = '{0, 1, 252, 253, 254, 255};
    int pbase, dbase, idx;
    logic [23:0] got, exp;
    pbase = popq.size(); dbase = done_cnt;
    select(8'd254, 8'd254, 2'd2, 9'd3, 1'b1, 1'b0);
    for (int yi = 0; yi < 6; yi++)
      for (int xi = 0; xi < 6; xi++)
        for (int ch = 0; ch < 3; ch++)
          send(8'(coords[xi]), 8'(coords[yi]), {2'(ch), 8'(coords[yi]), 8'(coords[xi])}, 1'b1);
    repeat (3) settle(1'b1);
    n_checks++; if (popq.size() - pbase !== 48) begin n_fail++; $display("FAIL edge_count: got %0d want 48", popq.size() - pbase); end
    idx = pbase;
    for (int y = 252; y < 256; y++)
      for (int x = 252; x < 256; x++)
        for (int ch = 0; ch < 3; ch++) begin
          exp = {3'(x - 252), 3'(y - 252), 2'(ch), 8'(y), 8'(x)};
          got = (idx < popq.size()) ? popq[idx] : 24'hxxxxxx;
          n_checks++; if (got !== exp) begin n_fail++; $display("FAIL edge_entry%0d: got %h want %h", idx - pbase, got, exp); end
          idx++;
        end
    n_checks++; if (done_cnt - dbase !== 0) begin n_fail++; $display("FAIL edge_no_done: got %0d want 0", done_cnt - dbase); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL edge_busy: got %b want 1", bus.busy); end
  endtask

  task automatic test_overflow();
    int pbase, dbase, idx;
    logic [23:0] got, exp;
    select(8'd10, 8'd10, 2'd1, 9'd1, 1'b0, 1'b0);
    settle(1'b0);
    pbase = popq.size(); dbase = done_cnt;
    for (int i = 0; i < 9; i++) begin
      send(8'(9 + i % 3), 8'(9 + i / 3), 18'(100 + i), 1'b0);
      settle(1'b0);
      if (i == 4) begin n_checks++; if (bus.issue_block !== 1'b0) begin n_fail++; $display("FAIL ovf_block_after5: got %b want 0", bus.issue_block); end end
      if (i == 5) begin n_checks++; if (bus.issue_block !== 1'b1) begin n_fail++; $display("FAIL ovf_block_after6: got %b want 1", bus.issue_block); end end
      if (i == 7) begin n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_after8: got %b want 0", bus.overflow); end end
      if (i == 8) begin n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_after9: got %b want 1", bus.overflow); end end
    end
    settle(1'b0);
    n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL ovf_done: got %0d want 1", done_cnt - dbase); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ovf_busy: got %b want 0", bus.busy); end
    drain();
    n_checks++; if (popq.size() - pbase !== 8) begin n_fail++; $display("FAIL ovf_count: got %0d want 8", popq.size() - pbase); end
    for (int i = 0; i < 8; i++) begin
      idx = pbase + i;
      exp = {3'(i % 3), 3'(i / 3), 18'(100 + i)};
      got = (idx < popq.size()) ? popq[idx] : 24'hxxxxxx;
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL ovf_entry%0d: got %h want %h", i, got, exp); end
    end
    n_checks++; if (bus.issue_block !== 1'b0) begin n_fail++; $display("FAIL ovf_block_released: got %b want 0", bus.issue_block); end
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    int pbase, idx;
    logic [23:0] got, exp;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow_reset: got %b want 0", bus.overflow); end
    select(8'd20, 8'd20, 2'd2, 9'd1, 1'b0, 1'b0);
    settle(1'b0);
    pbase = popq.size();
    for (int i = 0; i < 8; i++) send(8'(18 + i % 5), 8'(18 + i / 5), 18'(200 + i), 1'b0);
    settle(1'b0);
    n_checks++; if (bus.issue_block !== 1'b1) begin n_fail++; $display("FAIL pp_block_full: got %b want 1", bus.issue_block); end
    send(8'd21, 8'd19, 18'd208, 1'b1);
    settle(1'b0);
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL pp_no_overflow: got %b want 0", bus.overflow); end
    n_checks++; if (bus.issue_block !== 1'b1) begin n_fail++; $display("FAIL pp_still_full: got %b want 1", bus.issue_block); end
    drain();
    n_checks++; if (popq.size() - pbase !== 9) begin n_fail++; $display("FAIL pp_count: got %0d want 9", popq.size() - pbase); end
    for (int i = 0; i < 9; i++) begin
      idx = pbase + i;
      exp = {3'(i % 5), 3'(i / 5), 18'(200 + i)};
      got = (idx < popq.size()) ? popq[idx] : 24'hxxxxxx;
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL pp_entry%0d: got %h want %h", i, got, exp); end
    end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL pp_busy: got %b want 1", bus.busy); end
  endtask

  task automatic test_reselect();
    int pbase, dbase, idx;
    logic [23:0] got, exp;
    select(8'd30, 8'd30, 2'd1, 9'd1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'(29 + i), 8'd29, 18'(400 + i), 1'b0);
    settle(1'b0);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL resel_pre_valid: got %b want 1", bus.out_valid); end
    select(8'd40, 8'd40, 2'd1, 9'd1, 1'b0, 1'b1);
    settle(1'b0);
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL resel_flushed: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL resel_busy: got %b want 1", bus.busy); end
    pbase = popq.size(); dbase = done_cnt;
    for (int i = 0; i < 9; i++) begin
      send(8'(39 + i % 3), 8'(39 + i / 3), 18'(300 + i), 1'b1);
      if (i == 7) begin
        settle(1'b1); settle(1'b1);
        n_checks++; if (done_cnt - dbase !== 0) begin n_fail++; $display("FAIL resel_no_early_done: got %0d want 0", done_cnt - dbase); end
      end
    end
    settle(1'b1); settle(1'b1);
    n_checks++; if (done_cnt - dbase !== 1) begin n_fail++; $display("FAIL resel_done: got %0d want 1", done_cnt - dbase); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL resel_busy_end: got %b want 0", bus.busy); end
    drain();
    n_checks++; if (popq.size() - pbase !== 9) begin n_fail++; $display("FAIL resel_count: got %0d want 9", popq.size() - pbase); end
    for (int i = 0; i < 9; i++) begin
      idx = pbase + i;
      exp = {3'(i % 3), 3'(i / 3), 18'(300 + i)};
      got = (idx < popq.size()) ? popq[idx] : 24'hxxxxxx;
      n_checks++; if (got !== exp) begin n_fail++; $display("FAIL resel_entry%0d: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_edge();
    test_overflow();
    test_full_push_pop();
    test_reselect();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
